// File: rtl/surv_buffer_pkg.sv
// Shared Viterbi sizing: constraint length / traceback depth defaults and the
// derived widths used by the ACS, survivor buffer and traceback blocks.
package surv_buffer_pkg;

  localparam int unsigned K_DEF = 4;
  localparam int unsigned D_DEF = 6;

  function automatic int unsigned m_of(input int unsigned k);
    return k - 1;
  endfunction

  function automatic int unsigned s_of(input int unsigned k);
    return 1 << (k - 1);
  endfunction

  function automatic int unsigned aw_of(input int unsigned d);
    return $clog2(d);
  endfunction

  function automatic int unsigned fw_of(input int unsigned d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/surv_buffer_ram.sv
// Survivor storage: D rows of S decision bits, sync write, async bit read.
module surv_ram
  import surv_buffer_pkg::*;
#(
  parameter int unsigned D  = D_DEF,
  parameter int unsigned S  = s_of(K_DEF),
  parameter int unsigned AW = aw_of(D_DEF),
  parameter int unsigned M  = m_of(K_DEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [S-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  input  logic [M-1:0]  rd_sel,
  output logic          rd_bit_c
);

  logic [S-1:0] mem [D];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Row indices beyond the populated depth read as zero.
  always_comb begin
    rd_bit_c = 1'b0;
    if (32'(rd_addr) < D) begin
      rd_bit_c = mem[rd_addr][rd_sel];
    end
  end

endmodule

// File: rtl/surv_buffer.sv
// Survivor buffer: accepts ACS decision rows into a circular store and
// triggers one traceback per row once D rows are held.
module surv_buffer
  import surv_buffer_pkg::*;
#(
  parameter int unsigned K = K_DEF,
  parameter int unsigned D = D_DEF,
  localparam int unsigned M  = m_of(K),
  localparam int unsigned S  = s_of(K),
  localparam int unsigned AW = aw_of(D),
  localparam int unsigned FW = fw_of(D)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          surv_valid,
  input  logic [S-1:0]  surv_row,
  output logic          surv_ready,
  output logic [AW-1:0] wr_ptr,
  output logic [FW-1:0] fill,
  output logic          tb_start,
  input  logic          tb_done,
  input  logic [AW-1:0] tb_time,
  input  logic [M-1:0]  tb_state,
  output logic          tb_surv_bit
);

  typedef enum logic {
    ACCEPT = 1'b0,
    WAIT   = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          tb_start_q, tb_start_d;
  logic          accept_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCEPT;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      tb_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      tb_start_q <= tb_start_d;
    end
  end

  // Clear outranks both a pending row and a traceback completion.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    tb_start_d = 1'b0;
    accept_c   = 1'b0;
    if (clr) begin
      state_d  = ACCEPT;
      wr_ptr_d = '0;
      fill_d   = '0;
    end else begin
      case (state_q)
        ACCEPT: begin
          if (surv_valid) begin
            accept_c = 1'b1;
            wr_ptr_d = (wr_ptr_q == AW'(D - 1)) ? '0 : wr_ptr_q + AW'(1);
            fill_d   = (fill_q == FW'(D)) ? fill_q : fill_q + FW'(1);
            // A full window after this write means a traceback is due.
            if (fill_d == FW'(D)) begin
              tb_start_d = 1'b1;
              state_d    = WAIT;
            end
          end
        end
        WAIT: begin
          if (tb_done) begin
            state_d = ACCEPT;
          end
        end
        default: state_d = ACCEPT;
      endcase
    end
  end

  surv_ram #(
    .D  (D),
    .S  (S),
    .AW (AW),
    .M  (M)
  ) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (accept_c),
    .wr_addr  (wr_ptr_q),
    .wr_data  (surv_row),
    .rd_addr  (tb_time),
    .rd_sel   (tb_state),
    .rd_bit_c (tb_surv_bit)
  );

  assign surv_ready = (state_q == ACCEPT);
  assign wr_ptr     = wr_ptr_q;
  assign fill       = fill_q;
  assign tb_start   = tb_start_q;

endmodule

// File: tb/tb_surv_buffer.sv
// Bench for surv_buffer: accept-count reference model checked every cycle,
// plus directed literal checks and a traceback-driven streaming run.
module tb_surv_buffer;

  localparam int unsigned K  = 4;
  localparam int unsigned D  = 6;
  localparam int unsigned M  = 3;
  localparam int unsigned S  = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned FW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          surv_valid = 1'b0;
  logic [S-1:0]  surv_row = '0;
  logic          tb_done = 1'b0;
  logic [AW-1:0] tb_time = '0;
  logic [M-1:0]  tb_state = '0;
  logic          surv_ready;
  logic [AW-1:0] wr_ptr;
  logic [FW-1:0] fill;
  logic          tb_start;
  logic          tb_surv_bit;

  int n_checks = 0;
  int n_err = 0;

  surv_buffer #(.K(K), .D(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .surv_valid  (surv_valid),
    .surv_row    (surv_row),
    .surv_ready  (surv_ready),
    .wr_ptr      (wr_ptr),
    .fill        (fill),
    .tb_start    (tb_start),
    .tb_done     (tb_done),
    .tb_time     (tb_time),
    .tb_state    (tb_state),
    .tb_surv_bit (tb_surv_bit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: count of accepts since reset/clear plus a shadow store.
  int unsigned n_acc = 0;
  bit          waiting = 1'b0;
  bit          exp_tbs = 1'b0;
  logic [S-1:0] mdl_mem [D] = '{default: '0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_acc   = 0;
      waiting = 1'b0;
      exp_tbs = 1'b0;
      for (int i = 0; i < int'(D); i++) mdl_mem[i] = '0;
    end else begin
      exp_tbs = 1'b0;
      if (clr) begin
        n_acc   = 0;
        waiting = 1'b0;
      end else if (!waiting && surv_valid) begin
        mdl_mem[n_acc % D] = surv_row;
        n_acc++;
        if (n_acc >= D) begin
          waiting = 1'b1;
          exp_tbs = 1'b1;
        end
      end else if (waiting && tb_done) begin
        waiting = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic exp_bit;
    exp_bit = (32'(tb_time) < D) ? mdl_mem[tb_time][tb_state] : 1'b0;
    check("m_surv_ready", 32'(surv_ready), 32'(!waiting));
    check("m_wr_ptr", 32'(wr_ptr), n_acc % D);
    check("m_fill", 32'(fill), (n_acc < D) ? n_acc : D);
    check("m_tb_start", 32'(tb_start), 32'(exp_tbs));
    check("m_tb_surv_bit", 32'(tb_surv_bit), 32'(exp_bit));
  end

  initial begin
    int t;
    int pulses;
    int guard;
    logic rdy;
    logic [M-1:0] st;
    logic [S-1:0] row7;
    int dec_q[$];

    repeat (2) step();
    rst_n = 1'b1;
    check("rst_wr_ptr", 32'(wr_ptr), 0);
    check("rst_fill", 32'(fill), 0);
    check("rst_ready", 32'(surv_ready), 1);
    check("rst_tb_start", 32'(tb_start), 0);

    // Five rows alternating 01/00
    for (int i = 0; i < 5; i++) begin
      surv_valid = 1'b1;
      surv_row = (i % 2 == 0) ? 8'h01 : 8'h00;
      step();
    end
    surv_valid = 1'b0;
    check("fill5_wr_ptr", 32'(wr_ptr), 5);
    check("fill5_fill", 32'(fill), 5);
    check("fill5_tb_start", 32'(tb_start), 0);
    tb_time = 3'd2; tb_state = 3'd0; #1;
    check("fill5_read_2_0", 32'(tb_surv_bit), 1);
    tb_time = 3'd1; #1;
    check("fill5_read_1_0", 32'(tb_surv_bit), 0);

    // Sixth row completes the window
    surv_valid = 1'b1; surv_row = 8'h00;
    step();
    surv_valid = 1'b0;
    check("trig_tb_start", 32'(tb_start), 1);
    check("trig_wr_ptr", 32'(wr_ptr), 0);
    check("trig_ready", 32'(surv_ready), 0);
    check("trig_fill", 32'(fill), 6);
    step();
    check("trig_one_cycle", 32'(tb_start), 0);
    repeat (3) step();
    check("wait_ready", 32'(surv_ready), 0);
    tb_done = 1'b1;
    step();
    tb_done = 1'b0;
    check("done_ready", 32'(surv_ready), 1);

    // Seventh row wraps into slot 0
    row7 = 8'hA5;
    surv_valid = 1'b1; surv_row = row7;
    step();
    surv_valid = 1'b0;
    check("wrap_wr_ptr", 32'(wr_ptr), 1);
    check("wrap_tb_start", 32'(tb_start), 1);
    tb_time = 3'd0;
    for (int s = 0; s < int'(S); s++) begin
      tb_state = M'(s); #1;
      check("wrap_read_row7", 32'(tb_surv_bit), 32'(row7[s]));
    end

    // Clear while waiting, with competing valid and done
    surv_valid = 1'b1; surv_row = 8'h3C; tb_done = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0; surv_valid = 1'b0; tb_done = 1'b0;
    check("clr_wr_ptr", 32'(wr_ptr), 0);
    check("clr_fill", 32'(fill), 0);
    check("clr_ready", 32'(surv_ready), 1);
    check("clr_tb_start", 32'(tb_start), 0);
    tb_time = 3'd0; tb_state = 3'd0; #1;
    check("clr_kept_bit0", 32'(tb_surv_bit), 1);
    tb_state = 3'd3; #1;
    check("clr_kept_bit3", 32'(tb_surv_bit), 0);

    // Mid-run reset wipes memory
    rst_n = 1'b0;
    step();
    check("mrst_wr_ptr", 32'(wr_ptr), 0);
    check("mrst_fill", 32'(fill), 0);
    check("mrst_ready", 32'(surv_ready), 1);
    check("mrst_tb_start", 32'(tb_start), 0);
    for (int a = 0; a < 8; a++) begin
      for (int s = 0; s < int'(S); s++) begin
        tb_time = AW'(a); tb_state = M'(s);
        step();
        check("mrst_mem_zero", 32'(tb_surv_bit), 0);
      end
    end

    // First accept on the first edge after release
    rst_n = 1'b1; surv_valid = 1'b1; surv_row = 8'hFF;
    step();
    surv_valid = 1'b0;
    check("rel_wr_ptr", 32'(wr_ptr), 1);
    check("rel_fill", 32'(fill), 1);

    // Randomized traffic, clears, spurious done and occasional resets
    for (int c = 0; c < 800; c++) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      clr        = ($urandom_range(0, 31) == 0);
      surv_valid = ($urandom_range(0, 3) != 0);
      surv_row   = S'($urandom);
      tb_done    = ($urandom_range(0, 3) == 0);
      tb_time    = AW'($urandom_range(0, 7));
      tb_state   = M'($urandom);
      step();
    end
    rst_n = 1'b1; surv_valid = 1'b0; tb_done = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;

    // Streaming with a simple traceback responder walking back D rows
    t = 0; pulses = 0; guard = 0;
    surv_valid = 1'b1; surv_row = 8'h01;
    while (t < 50 && guard < 5000) begin
      rdy = surv_ready;
      step(); guard++;
      if (rdy) begin
        t++;
        surv_row = (t % 2 == 0) ? 8'h01 : 8'h00;
        if (t == 50) surv_valid = 1'b0;
      end
      if (tb_start) begin
        pulses++;
        st = '0;
        for (int j = 0; j < int'(D); j++) begin
          tb_time = AW'((t + 2 * int'(D) - 1 - j) % int'(D));
          tb_state = st; #1;
          if (j == 0) dec_q.push_back(int'(tb_surv_bit));
          st = {st[M-2:0], tb_surv_bit};
          step(); guard++;
        end
        tb_done = 1'b1;
        step(); guard++;
        tb_done = 1'b0;
      end
    end
    check("stream_rows", 32'(t), 50);
    check("stream_pulses", 32'(pulses), 45);
    check("stream_decs", 32'(dec_q.size()), 45);
    for (int i = 0; i < dec_q.size(); i++) begin
      check("stream_dec_bit", 32'(dec_q[i]), 32'(i % 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
